// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//   Owns the PC and sequences instruction fetch. It issues one req/ack read per
//   instruction to instruction memory. It hands the fetched word to decode over
//   a valid/ready handshake and applies branch/jump redirects from branch
//   resolution. Addresses are byte addresses. Memory is word-indexed, so any
//   PC at or above MEM_WORDS*4 faults and fetch halts until the next redirect.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   redirect_valid  branch/jump taken this cycle
//   redirect_pc     redirect target (bits[1:0] forced to 00)
//   imem_req        read request, held with imem_addr until imem_ack
//   imem_addr       byte address of the request
//   imem_ack        read data valid (may arrive in the same cycle as req)
//   imem_rdata      instruction word, sampled only on ack
//   instr_valid     instr/instr_pc hold a fetched instruction
//   instr_ready     decode accepts (transfer = valid & ready)
//   instr           fetched instruction
//   instr_pc        byte address of instr
//   fault           PC out of range; fetch halted
//   fetch_count     instructions transferred to decode (wraps)
// -----------------------------------------------------------------------------
module fetch_controller #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        fault,
   output logic [31:0] fetch_count
);

   // One bit wider than the PC so MEM_WORDS*4 = 2^32 would still compare correctly.
   localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 2;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      OUT   = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        squash_q, squash_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic        vld_q, vld_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic        fault_q, fault_d;
   logic [31:0] cnt_q, cnt_d;

   logic [31:0] redir_pc;
   logic        pc_oor;

   assign redir_pc = {redirect_pc[31:2], 2'b00};
   assign pc_oor   = ({1'b0, pc_q} >= LIMIT);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      squash_d = squash_q;
      req_d    = req_q;
      addr_d   = addr_q;
      vld_d    = vld_q;
      instr_d  = instr_q;
      ipc_d    = ipc_q;
      fault_d  = fault_q;
      cnt_d    = cnt_q;

      unique case (state_q)
         FETCH: begin
            // A redirect arriving here retargets the PC before anything is issued;
            // the range check then runs on the new PC next cycle.
            if (redirect_valid) begin
               pc_d = redir_pc;
            end else if (pc_oor) begin
               fault_d = 1'b1;
               state_d = FAULT;
            end else begin
               req_d   = 1'b1;
               addr_d  = pc_q;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_ack) begin
               req_d = 1'b0;
               if (squash_q || redirect_valid) begin
                  // Returning data belongs to the wrong path: drop it.
                  squash_d = 1'b0;
                  if (redirect_valid) pc_d = redir_pc;
                  state_d = FETCH;
               end else begin
                  instr_d = imem_rdata;
                  ipc_d   = addr_q;
                  vld_d   = 1'b1;
                  pc_d    = pc_q + 32'd4;
                  state_d = OUT;
               end
            end else if (redirect_valid) begin
               // Memory protocol forbids withdrawing the request, so mark it stale.
               squash_d = 1'b1;
               pc_d     = redir_pc;
            end
         end
         OUT: begin
            // Redirect beats a same-cycle ready: the held instruction is wrong-path.
            if (redirect_valid) begin
               vld_d   = 1'b0;
               pc_d    = redir_pc;
               state_d = FETCH;
            end else if (instr_ready) begin
               vld_d   = 1'b0;
               cnt_d   = cnt_q + 32'd1;
               state_d = FETCH;
            end
         end
         FAULT: begin
            if (redirect_valid) begin
               fault_d = 1'b0;
               pc_d    = redir_pc;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         squash_q <= 1'b0;
         req_q    <= 1'b0;
         addr_q   <= 32'd0;
         vld_q    <= 1'b0;
         instr_q  <= 32'd0;
         ipc_q    <= 32'd0;
         fault_q  <= 1'b0;
         cnt_q    <= 32'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         squash_q <= squash_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         vld_q    <= vld_d;
         instr_q  <= instr_d;
         ipc_q    <= ipc_d;
         fault_q  <= fault_d;
         cnt_q    <= cnt_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instr_valid = vld_q;
   assign instr       = instr_q;
   assign instr_pc    = ipc_q;
   assign fault       = fault_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//   Directed scenarios with cycle-exact checks, then a randomized run checked
//   against an architectural model: the expected stream of transferred PCs
//   (sequential +4, replaced by the latest redirect target) and the memory
//   contents, independent of how the controller sequences its requests.
// -----------------------------------------------------------------------------
module tb_fetch_controller;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        fault;
   logic [31:0] fetch_count;

   int n_chk  = 0;
   int n_fail = 0;

   // memory responder controls
   logic        auto_mem  = 1'b1;
   logic        rand_mem  = 1'b0;
   int          mem_delay = 0;
   logic        man_ack   = 1'b0;
   logic [31:0] man_rdata = 32'd0;
   logic        auto_ack  = 1'b0;
   logic [31:0] auto_rdata = 32'd0;
   int          wcnt = 0;
   int          cur_delay = 0;

   fetch_controller #(.RESET_PC(RESET_PC), .MEM_WORDS(1024)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc),
      .fault(fault), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign imem_ack   = auto_mem ? auto_ack   : man_ack;
   assign imem_rdata = auto_mem ? auto_rdata : man_rdata;

   // Memory model: acks after cur_delay cycles of request (0 = same cycle).
   always @(negedge clk) begin
      if (!imem_req || rst) begin
         wcnt      = 0;
         cur_delay = rand_mem ? int'($urandom_range(0, 3)) : mem_delay;
         auto_ack  = 1'b0;
      end else if (wcnt >= cur_delay) begin
         auto_ack   = 1'b1;
         auto_rdata = mem_word(imem_addr);
      end else begin
         auto_ack = 1'b0;
         wcnt++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b1;
      cyc(); cyc();
      n_chk++; if (imem_req !== 1'b0)     begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
      n_chk++; if (imem_addr !== 32'd0)   begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      n_chk++; if (instr_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      n_chk++; if (instr !== 32'd0)       begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
      n_chk++; if (instr_pc !== 32'd0)    begin n_fail++; $display("FAIL reset_ipc: got %h want 0", instr_pc); end
      n_chk++; if (fault !== 1'b0)        begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
      n_chk++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
   endtask

   // zero-wait memory, decode always ready: one instruction every 3 cycles
   task automatic test_basic();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*i))
            begin n_fail++; $display("FAIL basic_req%0d: got req=%b addr=%h want 1/%h", i, imem_req, imem_addr, 4*i); end
         cyc();
         n_chk++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4*i) || instr !== mem_word(32'(4*i)) || imem_req !== 1'b0)
            begin n_fail++; $display("FAIL basic_out%0d: got v=%b pc=%h ins=%h req=%b", i, instr_valid, instr_pc, instr, imem_req); end
         cyc();
         n_chk++; if (instr_valid !== 1'b0 || fetch_count !== 32'(i+1))
            begin n_fail++; $display("FAIL basic_xfer%0d: got v=%b cnt=%0d want 0/%0d", i, instr_valid, fetch_count, i+1); end
      end
   endtask

   task automatic test_wait_delay();
      cyc(); cyc(); cyc();  // filler fetch of 0xC so the next PC is 0x10
      n_chk++; if (fetch_count !== 32'd4) begin n_fail++; $display("FAIL delay_fill: got cnt=%0d want 4", fetch_count); end
      mem_delay = 3; instr_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
         cyc();
         n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0)
            begin n_fail++; $display("FAIL delay_hold%0d: got req=%b addr=%h v=%b want 1/10/0", j, imem_req, imem_addr, instr_valid); end
      end
      cyc();
      n_chk++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h10) || instr_pc !== 32'h10 || imem_req !== 1'b0)
         begin n_fail++; $display("FAIL delay_out: got v=%b ins=%h pc=%h req=%b", instr_valid, instr, instr_pc, imem_req); end
   endtask

   task automatic test_stall();
      for (int j = 0; j < 5; j++) begin
         cyc();
         n_chk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr !== mem_word(32'h10) || imem_req !== 1'b0 || fetch_count !== 32'd4)
            begin n_fail++; $display("FAIL stall%0d: got v=%b pc=%h ins=%h req=%b cnt=%0d", j, instr_valid, instr_pc, instr, imem_req, fetch_count); end
      end
      instr_ready = 1'b1;
      cyc();
      n_chk++; if (instr_valid !== 1'b0 || fetch_count !== 32'd5)
         begin n_fail++; $display("FAIL stall_release: got v=%b cnt=%0d want 0/5", instr_valid, fetch_count); end
   endtask

   task automatic test_redirect_wait();
      redirect_valid = 1'b1; redirect_pc = 32'h8;
      cyc();
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_fetch: got req=%b want 0", imem_req); end
      redirect_valid = 1'b0; mem_delay = 3;
      cyc();
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h8)
         begin n_fail++; $display("FAIL redir_req8: got req=%b addr=%h want 1/8", imem_req, imem_addr); end
      redirect_valid = 1'b1; redirect_pc = 32'h42;
      for (int j = 0; j < 3; j++) begin
         cyc();
         redirect_valid = 1'b0;
         n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0)
            begin n_fail++; $display("FAIL redir_hold%0d: got req=%b addr=%h v=%b want 1/8/0", j, imem_req, imem_addr, instr_valid); end
      end
      cyc();
      n_chk++; if (imem_req !== 1'b0 || instr_valid !== 1'b0)
         begin n_fail++; $display("FAIL redir_drop: got req=%b v=%b want 0/0", imem_req, instr_valid); end
      mem_delay = 0;
      cyc();
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h40)
         begin n_fail++; $display("FAIL redir_target: got req=%b addr=%h want 1/40", imem_req, imem_addr); end
      cyc();
      n_chk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== mem_word(32'h40))
         begin n_fail++; $display("FAIL redir_out: got v=%b pc=%h ins=%h", instr_valid, instr_pc, instr); end
      cyc();
      n_chk++; if (fetch_count !== 32'd6) begin n_fail++; $display("FAIL redir_count: got %0d want 6", fetch_count); end
   endtask

   task automatic test_fault();
      redirect_valid = 1'b1; redirect_pc = 32'h1000;
      cyc();
      redirect_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         cyc();
         n_chk++; if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0)
            begin n_fail++; $display("FAIL fault_hold%0d: got fault=%b req=%b v=%b want 1/0/0", j, fault, imem_req, instr_valid); end
      end
      redirect_valid = 1'b1; redirect_pc = 32'h20;
      cyc();
      redirect_valid = 1'b0;
      n_chk++; if (fault !== 1'b0 || imem_req !== 1'b0)
         begin n_fail++; $display("FAIL fault_clear: got fault=%b req=%b want 0/0", fault, imem_req); end
      cyc();
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h20)
         begin n_fail++; $display("FAIL fault_refetch: got req=%b addr=%h want 1/20", imem_req, imem_addr); end
      cyc();
      n_chk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr !== mem_word(32'h20))
         begin n_fail++; $display("FAIL fault_out: got v=%b pc=%h ins=%h", instr_valid, instr_pc, instr); end
      cyc();
      n_chk++; if (fetch_count !== 32'd7) begin n_fail++; $display("FAIL fault_count: got %0d want 7", fetch_count); end
   endtask

   task automatic test_reset_in_wait();
      auto_mem = 1'b0; man_ack = 1'b0;
      cyc();
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h24)
         begin n_fail++; $display("FAIL rstw_req: got req=%b addr=%h want 1/24", imem_req, imem_addr); end
      rst = 1'b1;
      cyc();
      n_chk++; if (imem_req !== 1'b0 || imem_addr !== 32'd0 || instr_valid !== 1'b0 || instr !== 32'd0 ||
                   instr_pc !== 32'd0 || fault !== 1'b0 || fetch_count !== 32'd0)
         begin n_fail++; $display("FAIL rstw_outputs: got req=%b addr=%h v=%b ins=%h pc=%h f=%b cnt=%0d", imem_req, imem_addr, instr_valid, instr, instr_pc, fault, fetch_count); end
      rst = 1'b0; man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
      cyc();
      n_chk++; if (instr_valid !== 1'b0 || fetch_count !== 32'd0 || imem_req !== 1'b1 || imem_addr !== RESET_PC)
         begin n_fail++; $display("FAIL rstw_lateack: got v=%b cnt=%0d req=%b addr=%h", instr_valid, fetch_count, imem_req, imem_addr); end
      man_ack = 1'b0; auto_mem = 1'b1; mem_delay = 0;
      cyc();
      n_chk++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== mem_word(RESET_PC))
         begin n_fail++; $display("FAIL rstw_refetch: got v=%b pc=%h ins=%h", instr_valid, instr_pc, instr); end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      int          exp_cnt;
      logic        prev_pend;
      logic [31:0] prev_addr;
      rst = 1'b1; redirect_valid = 1'b0; rand_mem = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      exp_pc = RESET_PC; exp_cnt = 0; prev_pend = 1'b0; prev_addr = 32'd0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         instr_ready    = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 9) == 0) redirect_pc = 32'h1000 + 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
         else                           redirect_pc = 32'($urandom_range(0, 1023) * 4 + $urandom_range(0, 3));
         #4;
         n_chk++; if (fetch_count !== 32'(exp_cnt))
            begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, fetch_count, exp_cnt); end
         if (prev_pend) begin
            n_chk++; if (imem_req !== 1'b1 || imem_addr !== prev_addr)
               begin n_fail++; $display("FAIL rnd_reqhold@%0d: got req=%b addr=%h want 1/%h", c, imem_req, imem_addr, prev_addr); end
         end
         if (fault) begin
            n_chk++; if (imem_req !== 1'b0 || instr_valid !== 1'b0)
               begin n_fail++; $display("FAIL rnd_faultquiet@%0d: got req=%b v=%b", c, imem_req, instr_valid); end
         end
         if (redirect_valid) begin
            exp_pc = redirect_pc & ~32'd3;
         end else if (instr_valid && instr_ready) begin
            n_chk++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc))
               begin n_fail++; $display("FAIL rnd_stream@%0d: got pc=%h ins=%h want %h/%h", c, instr_pc, instr, exp_pc, mem_word(exp_pc)); end
            exp_cnt++;
            exp_pc = exp_pc + 32'd4;
         end
         prev_pend = imem_req && !imem_ack;
         prev_addr = imem_addr;
      end
      redirect_valid = 1'b0;
      rand_mem = 1'b0;
      n_chk++; if (exp_cnt < 50) begin n_fail++; $display("FAIL rnd_progress: got %0d transfers want >=50", exp_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wait_delay();
      test_stall();
      test_redirect_wait();
      test_fault();
      test_reset_in_wait();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
